fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of `instruction_memory` and feeds the decode stage. It owns the program counter, drives the memory word address, and absorbs the memory's one-cycle synchronous read latency. It buffers fetched words in a 3-entry queue and presents them to decode through a valid/ready handshake. It also handles branch/jump redirects by flushing in-flight and buffered instructions.

## Interface
- `RESET_PC`, default 16'h0000: word address fetched first after reset.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `imem_a`  out  16  word address to `instruction_memory.a`, driven directly from the fetch PC register.
- `imem_rd`  in  32  `instruction_memory.rd`. Valid in the cycle after the address was issued.
- `redirect_valid`  in  1  branch/jump taken; flush and refetch.
- `redirect_pc`  in  16  target word address, sampled when `redirect_valid`=1.
- `out_valid`  out  1  `out_inst`/`out_pc` hold a fetched instruction.
- `out_ready`  in  1  decode accepts this cycle.
- `out_inst`  out  32  instruction word.
- `out_pc`  out  16  word address of `out_inst`.

## Operation
- **State**
  - `fetch_pc` (16b): next address to issue.
  - `inflight` (1b) plus `inflight_pc` (16b): an issue was made last cycle.
  - 3-entry FIFO of {pc[15:0], inst[31:0]} with `count` 0..3.
- **Issue**
  - `issue` = (`count` + `inflight` < 3) && !`redirect_valid`.
  - On `issue`: `inflight`<=1, `inflight_pc`<=`fetch_pc`, `fetch_pc`<=`fetch_pc`+1.
  - The increment is 16-bit and wraps 16'hFFFF -> 16'h0000.
  - When not issuing, `fetch_pc` holds and `inflight`<=0.
  - The issue decision uses registered state only. There is no combinational path from `out_ready` to `imem_a`.
- **Capture**
  - When `inflight`=1 and no redirect, push {`inflight_pc`, `imem_rd`} into the FIFO.
  - The credit rule guarantees the push never overflows, even with no pop.
  - `imem_rd` is ignored whenever `inflight`=0.
- **Output**
  - `out_valid` = (`count` != 0). `out_inst`/`out_pc` are the FIFO head.
  - When `count`=0, `out_inst` and `out_pc` are forced to 0.
  - Pop occurs when `out_valid` && `out_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
- **Redirect** (priority over everything)
  - Effect: `count`<=0, `inflight`<=0, `fetch_pc`<=`redirect_pc`.
  - A handshake completed in the redirect cycle counts as delivered; all other buffered or in-flight words are discarded.
  - Back-to-back redirects: the last one wins.
- **Reset**
  - `fetch_pc`=`RESET_PC`, `inflight`=0, `count`=0, `inflight_pc`=0.
  - Outputs during and after reset: `out_valid`=0, `out_inst`=0, `out_pc`=0, `imem_a`=`RESET_PC`.
  - A reset asserted mid-operation discards everything. Any stale `imem_rd` is ignored because `inflight`=0.

## Timing
- **Fetch latency**
  - Issue of address A in cycle t: memory registers RAM[A] at the end of t.
  - The block captures it at the end of t+1, and `out_valid`=1 with `out_pc`=A in cycle t+2. Issue to output is 2 cycles.
- **After reset release**
  - First issue in cycle 0 (first edge after `reset` deasserts).
  - `out_pc`=`RESET_PC` in cycle 2.
- **Throughput**
  - With `out_ready`=1: one instruction per cycle, no bubbles.
  - Steady state is `count`=1, `inflight`=1.
- **Stall**
  - While `out_ready`=0, the FIFO fills to 3 and issue stops.
  - The `out_*` outputs stay stable and no instruction is lost or duplicated.
  - After `out_ready` returns, output resumes the same cycle with the held head.
- **Redirect**
  - Redirect in cycle t: `out_valid`=0 in cycles t+1 and t+2.
  - `imem_a`=`redirect_pc` in t+1, and `out_pc`=`redirect_pc` in t+3.

## Test plan
- Reset with `RESET_PC`=0, memory word i = 32'hA000_0000+i, `out_ready`=1 -> `out_valid` first high in cycle 2; `out_pc`=0,1,2,3... in consecutive cycles with `out_inst`=A0000000, A0000001, ...
- Hold `out_ready`=0 for 6 cycles mid-stream -> `count` reaches 3, `imem_a` frozen, `out_pc` stable. On release, `out_pc` sequence continues without gap or repeat.
- Assert `redirect_valid` with `redirect_pc`=16'h0040 while the FIFO holds 3 entries -> `out_valid`=0 for 2 cycles, then `out_pc`=0x40, 0x41...; no pre-redirect word appears.
- Set `RESET_PC`=16'hFFFE -> `out_pc`=FFFE, FFFF, 0000, 0001 consecutively.
- Redirect in the same cycle as an accepted handshake, and separately two redirects in consecutive cycles (0x10 then 0x20) -> the accepted word counts once; the stream resumes at 0x20 only.
- Assert `reset` asynchronously mid-stream between edges -> `out_valid`, `out_inst`, `out_pc` go to 0 immediately. After release the stream restarts at `RESET_PC` with 2-cycle latency.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a one-cycle-latency
// synchronous instruction memory. Owns the fetch PC, keeps at most one
// read in flight and buffers returned words in a 3-entry FIFO that feeds
// decode through a valid/ready handshake. A redirect flushes everything
// and restarts fetch at the target address.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   imem_a         word address to instruction memory (fetch PC register)
//   imem_rd        memory read data, valid the cycle after the address
//   redirect_valid branch/jump taken: flush and refetch
//   redirect_pc    redirect target word address
//   out_valid      out_inst/out_pc hold a fetched instruction
//   out_ready      decode accepts this cycle
//   out_inst       instruction word (0 when empty)
//   out_pc         word address of out_inst (0 when empty)
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [15:0] out_pc
);

    localparam int unsigned DEPTH  = 3;
    localparam int unsigned PC_W   = 16;
    localparam int unsigned INST_W = 32;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned LOAD_W = 3;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    logic [PC_W-1:0]   r_fetch_pc;
    logic              r_inflight;
    logic [PC_W-1:0]   r_inflight_pc;
    fetch_entry_t      r_fifo [0:DEPTH-1];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic [LOAD_W-1:0] w_load;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_head;

    // Ring pointer advance over DEPTH entries.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    // Credit check counts the in-flight word so a later push never overflows.
    assign w_load  = LOAD_W'(r_count) + LOAD_W'(r_inflight);
    assign w_issue = (w_load < LOAD_W'(DEPTH)) && !redirect_valid;
    assign w_push  = r_inflight && !redirect_valid;
    assign w_pop   = out_valid && out_ready;

    assign w_head    = r_fifo[r_rd_ptr];
    assign imem_a    = r_fetch_pc;
    assign out_valid = (r_count != CNT_W'(0));
    assign out_inst  = out_valid ? w_head.inst : INST_W'(0);
    assign out_pc    = out_valid ? w_head.pc   : PC_W'(0);

    // Fetch PC and in-flight tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= PC_W'(0);
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + PC_W'(1);
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // Instruction FIFO; redirect empties it, a same-cycle pop already counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= PTR_W'(0);
            r_wr_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_fifo[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_rd_ptr <= PTR_W'(0);
            r_wr_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= '{pc: r_inflight_pc, inst: imem_rd};
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an instruction memory
// model (word a = 32'hA000_0000 + a), a queue-based reference model checked
// every cycle, a delivered-stream order check and literal spot checks.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [15:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [15:0] out_pc;

    logic [15:0] imem_a2;
    logic [31:0] imem_rd2;
    logic        out_valid2;
    logic [31:0] out_inst2;
    logic [15:0] out_pc2;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'hA000_0000 + {16'h0000, a};
    endfunction

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .reset(reset), .imem_a(imem_a2), .imem_rd(imem_rd2),
        .redirect_valid(1'b0), .redirect_pc(16'h0000),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_inst(out_inst2), .out_pc(out_pc2)
    );

    // Synchronous-read instruction memories.
    always @(posedge clk) begin
        imem_rd  <= mem_word(imem_a);
        imem_rd2 <= mem_word(imem_a2);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: words the block has fetched and not yet delivered.
    logic [15:0] m_q[$];
    logic        m_pend;
    logic [15:0] m_pend_pc;
    logic [15:0] m_fpc;
    logic [15:0] exp_next;

    initial begin
        bit popped;
        bit iss;
        m_pend = 1'b0; m_pend_pc = 16'h0; m_fpc = 16'h0000; exp_next = 16'h0000;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_q.delete();
                m_pend = 1'b0;
                m_fpc = 16'h0000;
                exp_next = 16'h0000;
            end else begin
                popped = (m_q.size() != 0) && out_ready;
                if (redirect_valid) begin
                    m_q.delete();
                    m_pend = 1'b0;
                    m_fpc = redirect_pc;
                    exp_next = redirect_pc;
                end else begin
                    iss = (m_q.size() + int'(m_pend)) < 3;
                    if (popped) void'(m_q.pop_front());
                    if (m_pend) m_q.push_back(m_pend_pc);
                    m_pend = iss;
                    if (iss) begin
                        m_pend_pc = m_fpc;
                        m_fpc = m_fpc + 16'h1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus delivery order.
    initial begin
        forever begin
            @(negedge clk);
            chk("valid", {31'h0, out_valid}, {31'h0, m_q.size() != 0});
            chk("pc", {16'h0, out_pc}, (m_q.size() != 0) ? {16'h0, m_q[0]} : 32'h0);
            chk("inst", out_inst, (m_q.size() != 0) ? mem_word(m_q[0]) : 32'h0);
            chk("imem_a", {16'h0, imem_a}, {16'h0, m_fpc});
            if (out_valid && out_ready) begin
                chk("seq", {16'h0, out_pc}, {16'h0, exp_next});
                exp_next = exp_next + 16'h1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0;
        repeat (3) step();
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_pc", {16'h0, out_pc}, 32'h0);
        chk("rst_inst", out_inst, 32'h0);
        chk("rst_imem_a2", {16'h0, imem_a2}, 32'h0000_FFFE);

        // Start-up latency and the wrapping instance.
        reset = 1'b0;
        step();
        chk("c1_valid", {31'h0, out_valid}, 32'h0);
        step();
        chk("c2_valid", {31'h0, out_valid}, 32'h1);
        chk("c2_pc", {16'h0, out_pc}, 32'h0);
        chk("c2_inst", out_inst, 32'hA000_0000);
        chk("w_pc0", {16'h0, out_pc2}, 32'h0000_FFFE);
        chk("w_inst0", out_inst2, 32'hA000_FFFE);
        step();
        chk("c3_pc", {16'h0, out_pc}, 32'h1);
        chk("w_pc1", {16'h0, out_pc2}, 32'h0000_FFFF);
        step();
        chk("c4_inst", out_inst, 32'hA000_0002);
        chk("w_pc2", {16'h0, out_pc2}, 32'h0);
        chk("w_inst2", out_inst2, 32'hA000_0000);
        step();
        chk("w_pc3", {16'h0, out_pc2}, 32'h1);

        // Stall for 6 cycles.
        out_ready = 1'b0;
        repeat (6) step();
        chk("stall_pc", {16'h0, out_pc}, 32'h3);
        chk("stall_imem_a", {16'h0, imem_a}, 32'h6);
        out_ready = 1'b1;
        step();
        chk("resume_pc", {16'h0, out_pc}, 32'h4);
        repeat (3) step();
        chk("resume_pc3", {16'h0, out_pc}, 32'h7);

        // Redirect with a full FIFO.
        out_ready = 1'b0;
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect_valid = 1'b0; out_ready = 1'b1;
        chk("rd_valid1", {31'h0, out_valid}, 32'h0);
        chk("rd_imem_a", {16'h0, imem_a}, 32'h40);
        step();
        chk("rd_valid2", {31'h0, out_valid}, 32'h0);
        step();
        chk("rd_pc", {16'h0, out_pc}, 32'h40);
        chk("rd_inst", out_inst, 32'hA000_0040);
        repeat (2) step();

        // Redirect during a handshake, then back-to-back redirects.
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        step();
        chk("bb_imem_a1", {16'h0, imem_a}, 32'h10);
        redirect_pc = 16'h0020;
        step();
        redirect_valid = 1'b0;
        chk("bb_imem_a2", {16'h0, imem_a}, 32'h20);
        step();
        chk("bb_valid", {31'h0, out_valid}, 32'h0);
        step();
        chk("bb_pc", {16'h0, out_pc}, 32'h20);
        repeat (2) step();

        // Asynchronous reset between edges.
        #1 reset = 1'b1;
        #1;
        chk("ar_valid", {31'h0, out_valid}, 32'h0);
        chk("ar_pc", {16'h0, out_pc}, 32'h0);
        chk("ar_inst", out_inst, 32'h0);
        chk("ar_imem_a", {16'h0, imem_a}, 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("ar_c1_valid", {31'h0, out_valid}, 32'h0);
        step();
        chk("ar_c2_pc", {16'h0, out_pc}, 32'h0);
        chk("ar_c2_valid", {31'h0, out_valid}, 32'h1);
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
